// File: rtl/candy_pkg.sv
// Shared types and key/request encodings for the candy machine front panel
// and controller.
package candy_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HOLD
    } kp_state_t;

    localparam logic [3:0] KEY_COIN50  = 4'd0;
    localparam logic [3:0] KEY_COIN100 = 4'd1;
    localparam logic [3:0] KEY_COIN200 = 4'd2;
    localparam logic [3:0] KEY_CANDY   = 4'd3;
    localparam logic [3:0] KEY_CANCEL  = 4'd7;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_50   = 2'b01;
    localparam logic [1:0] COIN_100  = 2'b10;
    localparam logic [1:0] COIN_200  = 2'b11;

    localparam logic [1:0] BTN_NONE   = 2'b00;
    localparam logic [1:0] BTN_CANDY  = 2'b01;
    localparam logic [1:0] BTN_CANCEL = 2'b10;

    function automatic logic is_one_hot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Callers only pass one-hot values; anything else maps to index 0.
    function automatic logic [1:0] row_index(input logic [3:0] v);
        case (v)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] col_index(input logic [2:0] c);
        case (c)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] coin_of(input logic [3:0] code);
        case (code)
            KEY_COIN50:  return COIN_50;
            KEY_COIN100: return COIN_100;
            KEY_COIN200: return COIN_200;
            default:     return COIN_NONE;
        endcase
    endfunction

    function automatic logic [1:0] btn_of(input logic [3:0] code);
        case (code)
            KEY_CANDY:  return BTN_CANDY;
            KEY_CANCEL: return BTN_CANCEL;
            default:    return BTN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer bringing the raw keypad rows into the clk domain.
module row_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 3x4 keypad scanner: column drive, debounce, multi-key rejection and
// one-shot key events decoded into coin/button request pulses.
module keypad_scanner
    import candy_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [2:0] col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [1:0] coin,
    output logic [1:0] btn
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

    logic [3:0]       row_s;
    logic [DIV_W-1:0] dwell;
    logic             sample;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] deb_next;
    logic             deb_done;
    logic [3:0]       pattern;
    logic [3:0]       code_now;
    kp_state_t        state;

    row_sync #(.WIDTH(4)) u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_in),
        .q     (row_s)
    );

    assign sample   = (dwell == DIV_W'(SCAN_DIV - 1));
    assign deb_next = deb_cnt + DEB_W'(1);
    assign deb_done = (deb_next == DEB_W'(DEBOUNCE_CNT));
    assign code_now = {col_index(col), row_index(row_s)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell <= '0;
        end else if (sample) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + DIV_W'(1);
        end
    end

    // Everything except the dwell counter only moves on sample edges; the
    // event outputs are forced low every other cycle so they stay one-shot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            col       <= 3'b001;
            pattern   <= '0;
            deb_cnt   <= '0;
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            coin      <= COIN_NONE;
            btn       <= BTN_NONE;
        end else begin
            key_valid <= 1'b0;
            coin      <= COIN_NONE;
            btn       <= BTN_NONE;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (is_one_hot4(row_s)) begin
                            pattern <= row_s;
                            deb_cnt <= DEB_W'(1);
                            state   <= DEBOUNCE;
                        end else begin
                            col <= {col[1:0], col[2]};
                        end
                    end
                    DEBOUNCE: begin
                        if (row_s == pattern) begin
                            if (deb_done) begin
                                key_code  <= code_now;
                                key_valid <= 1'b1;
                                coin      <= coin_of(code_now);
                                btn       <= btn_of(code_now);
                                deb_cnt   <= '0;
                                state     <= HOLD;
                            end else begin
                                deb_cnt <= deb_next;
                            end
                        end else begin
                            deb_cnt <= '0;
                            col     <= {col[1:0], col[2]};
                            state   <= SCAN;
                        end
                    end
                    HOLD: begin
                        if (row_s != 4'd0) begin
                            deb_cnt <= '0;
                        end else if (deb_done) begin
                            deb_cnt <= '0;
                            col     <= {col[1:0], col[2]};
                            state   <= SCAN;
                        end else begin
                            deb_cnt <= deb_next;
                        end
                    end
                    default: begin
                        deb_cnt <= '0;
                        col     <= 3'b001;
                        state   <= SCAN;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives the
// rows from the DUT's columns, and a cycle model of the scanning rules is
// compared against the DUT every cycle.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] row_in;
    logic [2:0] col;
    logic       key_valid;
    logic [3:0] key_code;
    logic [1:0] coin;
    logic [1:0] btn;

    logic [11:0] pressed = 12'd0;
    bit          cmp_en  = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col       (col),
        .key_valid (key_valid),
        .key_code  (key_code),
        .coin      (coin),
        .btn       (btn)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its driven column.
    function automatic logic [3:0] keypad_rows(input logic [2:0] c, input logic [11:0] p);
        logic [3:0] r;
        r = 4'd0;
        for (int k = 0; k < 3; k++)
            if (c[k]) r = r | p[k*4 +: 4];
        return r;
    endfunction

    always @(posedge clk) begin
        #2;
        row_in = keypad_rows(col, pressed);
    end

    task automatic check_output(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    endtask

    // Reference model: what the scanner must do, cycle by cycle.
    int m_phase = 0, m_col = 0, m_mode = 0, m_pat = 0, m_cnt = 0, m_code = 0;
    int m_s1 = 0, m_s2 = 0, m_rs = 0, m_row = 0;
    bit m_valid = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_col = 0; m_mode = 0; m_pat = 0; m_cnt = 0;
            m_code = 0; m_valid = 0; m_s1 = 0; m_s2 = 0;
        end else begin
            m_rs    = m_s2;
            m_valid = 0;
            if (m_phase == SCAN_DIV - 1) begin
                if (m_mode == 0) begin
                    if ($countones(m_rs) == 1) begin
                        m_mode = 1; m_pat = m_rs; m_cnt = 1;
                    end else m_col = (m_col + 1) % 3;
                end else if (m_mode == 1) begin
                    if (m_rs == m_pat) begin
                        m_cnt++;
                        if (m_cnt == DEB) begin
                            m_row = 0;
                            for (int b = 0; b < 4; b++) if (m_rs == (1 << b)) m_row = b;
                            m_code = m_col * 4 + m_row;
                            m_valid = 1; m_cnt = 0; m_mode = 2;
                        end
                    end else begin
                        m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 3;
                    end
                end else begin
                    if (m_rs == 0) begin
                        m_cnt++;
                        if (m_cnt == DEB) begin
                            m_mode = 0; m_cnt = 0; m_col = (m_col + 1) % 3;
                        end
                    end else m_cnt = 0;
                end
            end
            m_phase = (m_phase + 1) % SCAN_DIV;
            m_s2 = m_s1;
            m_s1 = int'(row_in);
        end
    end

    function automatic logic [1:0] exp_coin(input bit v, input int code);
        if (!v) return 2'b00;
        case (code)
            0: return 2'b01;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] exp_btn(input bit v, input int code);
        if (!v) return 2'b00;
        case (code)
            3: return 2'b01;
            7: return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("col", 8'(col), 8'(3'b001 << m_col));
            check_output("key_valid", 8'(key_valid), 8'(m_valid));
            check_output("key_code", 8'(key_code), 8'(m_code));
            check_output("coin", 8'(coin), 8'(exp_coin(m_valid, m_code)));
            check_output("btn", 8'(btn), 8'(exp_btn(m_valid, m_code)));
        end
    end

    task automatic apply_stimulus(input logic [11:0] keys, input int cycles);
        @(posedge clk); #1;
        pressed = keys;
        repeat (cycles) @(posedge clk);
    endtask

    task automatic pulse_reset(input int cycles);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    int  lat;
    int  pulses;
    bit  seen;
    int  sel;
    int  k1, k2;

    initial begin
        reset  = 1'b0;
        row_in = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check_output("reset_col", 8'(col), 8'h01);
        check_output("reset_valid", 8'(key_valid), 8'h00);
        check_output("reset_code", 8'(key_code), 8'h00);

        // Coin 50 held from release: event on the 12th edge after release.
        @(posedge clk); #1;
        pressed = 12'h001;
        @(posedge clk); #1;
        reset = 1'b1;
        lat = 0;
        seen = 0;
        for (int i = 1; i <= 100 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            if (key_valid) begin lat = i; seen = 1; end
        end
        check_output("coin50_latency", 8'(lat), 8'd12);
        check_output("coin50_code", 8'(key_code), 8'h00);
        check_output("coin50_coin", 8'(coin), 8'h01);
        pulses = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (key_valid) pulses++;
        end
        check_output("no_autorepeat", 8'(pulses), 8'd0);

        // Cancel key after a full release.
        apply_stimulus(12'h000, 40);
        @(posedge clk); #1;
        pressed = 12'h080;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk); @(negedge clk);
            if (key_valid) seen = 1;
        end
        check_output("cancel_seen", 8'(seen), 8'd1);
        check_output("cancel_code", 8'(key_code), 8'h07);
        check_output("cancel_btn", 8'(btn), 8'h02);
        apply_stimulus(12'h000, 40);

        // Reset between the 2nd and 3rd matching samples.
        pulse_reset(2);
        @(posedge clk); #1;
        pressed = 12'h001;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_output("midreset_col", 8'(col), 8'h01);
        check_output("midreset_valid", 8'(key_valid), 8'h00);
        check_output("midreset_code", 8'(key_code), 8'h00);
        check_output("midreset_coin", 8'(coin), 8'h00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        apply_stimulus(12'h000, 40);

        // Randomized presses, multi-key, bounces and resets against the model.
        for (int it = 0; it < 160; it++) begin
            sel = $urandom_range(0, 11);
            k1 = $urandom_range(0, 11);
            k2 = $urandom_range(0, 11);
            if (sel <= 4) begin
                apply_stimulus(12'(1 << k1), $urandom_range(10, 60));
            end else if (sel <= 6) begin
                apply_stimulus(12'((1 << k1) | (1 << k2)), $urandom_range(10, 50));
                apply_stimulus(12'(1 << k1), $urandom_range(10, 40));
            end else if (sel == 7) begin
                apply_stimulus(12'(1 << k1), $urandom_range(1, 8));
                apply_stimulus(12'h000, $urandom_range(1, 8));
            end else if (sel == 8) begin
                apply_stimulus(12'(1 << k1), $urandom_range(20, 40));
                apply_stimulus(12'h000, $urandom_range(3, 9));
                apply_stimulus(12'(1 << k1), $urandom_range(5, 15));
            end else if (sel == 9) begin
                pulse_reset($urandom_range(1, 3));
            end else begin
                apply_stimulus(12'h000, $urandom_range(5, 30));
            end
        end
        apply_stimulus(12'h000, 40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
